// File: rtl/sram_xbar_n.sv
// sram_xbar_n: 1-master to NUM_SLAVES SRAM-port interconnect with priority address decode and miss handling.
// Latency: read data 1 cycle after master_ena (REG_REQ=0) or 2 cycles (REG_REQ=1); one access per cycle, no bubbles.
// Backpressure: none; SRAM ports accept every cycle, so each request is issued to one slave or dropped as a miss.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   master_addra/dina/ena/wea     master SRAM request; master_douta returns read data
//   slave_addra/dina              packed per-slave slices, broadcast copies of the request
//   slave_ena/wea                 per-slave enables, only the decoded slave is enabled
//   slave_douta                   packed per-slave read data
//   miss_clear                    zero the miss counter
//   miss_valid/addr/count         decode-miss pulse, last miss address, saturating count
module sram_xbar_n #(
   parameter int                             LEN_ADDR   = 64,
   parameter int                             LEN_DATA   = 64,
   parameter int                             NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLV_BASE   = '0,
   parameter logic [NUM_SLAVES*LEN_ADDR-1:0] SLV_MASK   = '0,
   parameter logic [63:0]                    MISS_DATA  = 64'hDEAD_BEEF_DEAD_BEEF,
   parameter bit                             REG_REQ    = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [LEN_ADDR-1:0]                master_addra,
   input  logic [LEN_DATA-1:0]                master_dina,
   output logic [LEN_DATA-1:0]                master_douta,
   input  logic                               master_ena,
   input  logic [LEN_DATA/8-1:0]              master_wea,
   output logic [NUM_SLAVES*LEN_ADDR-1:0]     slave_addra,
   output logic [NUM_SLAVES*LEN_DATA-1:0]     slave_dina,
   input  logic [NUM_SLAVES*LEN_DATA-1:0]     slave_douta,
   output logic [NUM_SLAVES-1:0]              slave_ena,
   output logic [NUM_SLAVES*LEN_DATA/8-1:0]   slave_wea,
   input  logic                               miss_clear,
   output logic                               miss_valid,
   output logic [LEN_ADDR-1:0]                miss_addr,
   output logic [15:0]                        miss_count
);

   localparam int                  LEN_WE    = LEN_DATA / 8;
   localparam int                  SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam logic [LEN_DATA-1:0] MISS_WORD = LEN_DATA'(MISS_DATA);

   // Address decode; scanning downwards lets the lowest matching index win.
   logic [SEL_W-1:0] dec_sel;
   logic             dec_miss;

   always_comb begin
      dec_sel  = '0;
      dec_miss = 1'b1;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if ((master_addra & SLV_MASK[i*LEN_ADDR +: LEN_ADDR]) == SLV_BASE[i*LEN_ADDR +: LEN_ADDR]) begin
            dec_sel  = SEL_W'(i);
            dec_miss = 1'b0;
         end
      end
   end

   // Slave-side request: either the live master request or a one-cycle registered copy.
   logic [LEN_ADDR-1:0] req_addr;
   logic [LEN_DATA-1:0] req_dina;
   logic                req_ena;
   logic [LEN_WE-1:0]   req_wea;
   logic [SEL_W-1:0]    req_sel;
   logic                req_miss;

   generate
      if (REG_REQ) begin : g_req_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               req_ena  <= 1'b0;
               req_addr <= '0;
               req_dina <= '0;
               req_wea  <= '0;
               req_sel  <= '0;
               req_miss <= 1'b1;
            end else begin
               req_ena  <= master_ena;
               req_addr <= master_addra;
               req_dina <= master_dina;
               req_wea  <= master_wea;
               req_sel  <= dec_sel;
               req_miss <= dec_miss;
            end
         end
      end else begin : g_req_comb
         assign req_ena  = master_ena;
         assign req_addr = master_addra;
         assign req_dina = master_dina;
         assign req_wea  = master_wea;
         assign req_sel  = dec_sel;
         assign req_miss = dec_miss;
      end
   endgenerate

   // Enables are gated by rst so nothing reaches the SRAMs during reset, in either mode.
   always_comb begin
      slave_ena = '0;
      slave_wea = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!rst && req_ena && !req_miss && (req_sel == SEL_W'(i))) begin
            slave_ena[i]                  = 1'b1;
            slave_wea[i*LEN_WE +: LEN_WE] = req_wea;
         end
      end
   end

   assign slave_addra = {NUM_SLAVES{req_addr}};
   assign slave_dina  = {NUM_SLAVES{req_dina}};

   // Response tracking: sel_q/miss_q follow the issued request and hold while idle,
   // so douta keeps showing the last selected slave like a plain SRAM output.
   logic [SEL_W-1:0] sel_q;
   logic             miss_q;
   logic             miss_evt;

   assign miss_evt = !rst && req_ena && req_miss;

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q      <= '0;
         miss_q     <= 1'b1;
         miss_valid <= 1'b0;
         miss_addr  <= '0;
         miss_count <= '0;
      end else begin
         if (req_ena) begin
            sel_q  <= req_sel;
            miss_q <= req_miss;
         end
         miss_valid <= miss_evt;
         if (miss_evt) begin
            miss_addr <= req_addr;
         end
         // A clear coinciding with a miss still counts that miss.
         if (miss_clear) begin
            miss_count <= miss_evt ? 16'd1 : 16'd0;
         end else if (miss_evt && (miss_count != 16'hFFFF)) begin
            miss_count <= miss_count + 16'd1;
         end
      end
   end

   always_comb begin
      master_douta = MISS_WORD;
      if (!miss_q) begin
         for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
               master_douta = slave_douta[i*LEN_DATA +: LEN_DATA];
            end
         end
      end
   end

endmodule

// File: doc/sram_xbar_n.md
Name: sram_xbar_n

Overview:
- Parametrised 1-master to N-slave SRAM-port interconnect. Replaces chains of 2-way sram_xbar instances in SoC tops.
- Decodes the master address against per-slave base/mask pairs and routes ena/wea to the one selected slave. It broadcasts addra/dina to all slaves and returns the selected slave's douta with SRAM read timing.
- Adds behaviour the 2-way xbar lacks: priority decode, an optional registered request stage, and decode-miss handling (fixed read data, dropped writes, captured miss address, saturating miss counter).

Parameters:
- LEN_ADDR, 64, address width.
- LEN_DATA, 64, data width; multiple of 8.
- NUM_SLAVES, 4, slave count, 1..16.
- SLV_BASE, 0, packed NUM_SLAVES*LEN_ADDR bits; slice i is slave i base.
- SLV_MASK, 0, packed NUM_SLAVES*LEN_ADDR bits; slice i is slave i compare mask.
- MISS_DATA, 64'hDEAD_BEEF_DEAD_BEEF, read data on decode miss; truncated to LEN_DATA.
- REG_REQ, 0, 1 = register the request path (adds 1 cycle latency).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- master_addra  in  LEN_ADDR  master address.
- master_dina  in  LEN_DATA  master write data.
- master_douta  out  LEN_DATA  master read data.
- master_ena  in  1  access enable.
- master_wea  in  LEN_DATA/8  byte write enables.
- slave_addra  out  NUM_SLAVES*LEN_ADDR  per-slave address (broadcast).
- slave_dina  out  NUM_SLAVES*LEN_DATA  per-slave write data (broadcast).
- slave_douta  in  NUM_SLAVES*LEN_DATA  per-slave read data.
- slave_ena  out  NUM_SLAVES  per-slave enable.
- slave_wea  out  NUM_SLAVES*LEN_DATA/8  per-slave byte enables.
- miss_clear  in  1  zero miss_count.
- miss_valid  out  1  one-cycle pulse per missed access.
- miss_addr  out  LEN_ADDR  address of most recent miss.
- miss_count  out  16  saturating miss count.

Behaviour:
- Decode:
  - hit[i] = ((addr & SLV_MASK[i]) == SLV_BASE[i]).
  - Lowest index wins on multiple hits.
  - miss = no hit.
- Request path, REG_REQ=0: combinational.
  - slave_ena[i] = master_ena & sel==i.
  - slave_wea[i] = master_wea when slave_ena[i], else 0.
  - addra/dina are copied to every slave slice.
- Request path, REG_REQ=1: addra/dina/ena/wea/decode are registered. Slaves see the request 1 cycle late; the stage register ena resets to 0.
- Response tracking: sel_q/miss_q are updated on the cycle the slave-side request has ena=1 and are held otherwise.
- master_douta = miss_q ? MISS_DATA : slave_douta[sel_q].
- Read latency from master_ena: 1 cycle (REG_REQ=0) or 2 cycles (REG_REQ=1).
- With ena low, douta keeps tracking the last selected slave, preserving SRAM hold semantics.
- Miss access:
  - No slave_ena or wea is asserted; a write miss is silently dropped.
  - Read data is MISS_DATA, returned with normal latency.
  - miss_valid pulses in the data-return cycle; miss_addr is captured in the same cycle.
- miss_count: +1 per miss, saturating at 16'hFFFF.
  - miss_clear alone sets 0.
  - miss_clear together with a miss sets 1 (the miss is never lost).
- Back-to-back accesses to different slaves every cycle are supported with no bubbles. Each response selects from its own request's slave.
- Reset:
  - slave_ena and slave_wea are forced 0 while rst=1 (both modes).
  - sel_q=0, miss_q=1, so master_douta=MISS_DATA until the first access.
  - miss_valid=0, miss_addr=0, miss_count=0.
  - The REG_REQ stage is flushed.
- Reset mid-access: an in-flight request is discarded and no miss_valid is produced. The first post-reset access behaves normally.

Test Plan:
- Setup: NUM_SLAVES=4, base i = i<<28, mask 0xF000_0000, REG_REQ=0; slave models are 1-cycle SRAMs.
- Write 0x1122334455667788 with wea=0xFF to 0x2000_0010, then read it -> only slave_ena[2] toggles; master_douta=0x1122334455667788 one cycle after the read ena.
- Back-to-back reads to 0x0000_0000, 0x3000_0000, 0x1000_0000 in consecutive cycles -> douta returns slave 0, 3, 1 data on consecutive cycles.
- Read 0x7000_0000 -> no slave_ena; next cycle douta=0xDEADBEEFDEADBEEF, miss_valid=1, miss_addr=0x7000_0000, miss_count=1. Write miss -> no slave_wea.
- Overlapping decode (slave 1 mask 0) with access 0x1000_0000 -> slave 0 or 1 per priority, never both enabled.
- Force miss_count to 0xFFFF and miss again -> stays 0xFFFF. miss_clear with a simultaneous miss -> count=1.
- REG_REQ=1 read of slave 2 -> slave_ena[2] asserted 1 cycle after master_ena; data at +2. Assert rst with a request in the stage -> no slave_ena, douta=MISS_DATA.
